inst_fetch: RTL and testbench
=============================

Name: inst_fetch

Overview:
Instruction fetch unit that supplies the 16-bit INST word consumed by the CPU sequencer.
- Holds the program counter and issues word reads to instruction memory over a req/ack handshake (variable latency).
- Buffers returned words in a small prefetch FIFO.
- Presents them to the CPU with a valid/ready handshake; the CPU pops one word per IF state.
- Accepts a redirect (jump) from the CPU that flushes buffered and in-flight words.

Parameters:
AW, 8, instruction address width (word addressed)
DEPTH, 2, prefetch FIFO entries (power of two, >=2)
RESET_PC, 0, fetch address after reset

Ports:
ck  in  1  clock, rising edge
res  in  1  asynchronous reset, active-low (asserted when 0)
mem_req  out  1  memory read request, held until mem_ack
mem_addr  out  AW  read word address, stable while mem_req=1
mem_ack  in  1  one-cycle pulse: mem_rdata valid, request complete
mem_rdata  in  16  read data
inst  out  16  instruction word at FIFO head
inst_pc  out  AW  address of inst
inst_valid  out  1  head entry valid
inst_ready  in  1  CPU pops head when inst_valid & inst_ready
redirect  in  1  one-cycle pulse: flush and restart at redirect_pc
redirect_pc  in  AW  new fetch address

Behaviour:
- Reset (res=0, async): mem_req=0, mem_addr=RESET_PC, fetch_pc=RESET_PC, FIFO empty, inst_valid=0, inst=0, inst_pc=0, state=IDLE.
- FIFO: registered outputs; inst/inst_pc/inst_valid reflect the head. Push on a kept mem_ack; pop on inst_valid&inst_ready.
- Occupancy: entries + outstanding (0/1) never exceeds DEPTH.
- State machine:
  - IDLE: if occupancy+outstanding < DEPTH and no redirect, assert mem_req with mem_addr=fetch_pc -> WAIT (mem_req rises the cycle after the decision).
  - WAIT: hold mem_req/mem_addr. On mem_ack: push {mem_rdata, mem_addr}, fetch_pc += 1 (wraps mod 2^AW). If space remains after the push and any same-cycle pop, issue the next request back-to-back (mem_req stays 1, mem_addr updates); otherwise go to IDLE with mem_req=0.
  - DRAIN: entered on a redirect while a request is outstanding. Hold mem_req until mem_ack, discard that data (no push), then request redirect_pc -> WAIT.
- Redirect: FIFO flushed the same edge (inst_valid=0 next cycle); fetch_pc <= redirect_pc.
  - Redirect with no request outstanding -> IDLE, new request next cycle.
  - Redirect on the same cycle as mem_ack -> data discarded, no DRAIN needed, request redirect_pc.
  - Redirect overrides a simultaneous pop.
  - A second redirect during DRAIN updates the target; the last one wins.
- Latency: empty FIFO, zero-wait memory (ack the cycle after req) -> first inst_valid 3 cycles after res deasserts; sustained throughput 1 word per 2 cycles with single outstanding.
- Full FIFO: no request issued; a pop re-enables requesting next cycle.
- Empty FIFO: inst_valid=0; inst holds its last value.
- mem_ack while mem_req=0 is ignored.

Optional Feature:
IFU_HALT_EN
- Defined: when a pushed word has opcode bits [15:12]=4'hF (HALT), stop issuing requests after it until a redirect. Words already in the FIFO still drain to the CPU.
- Undefined: 4'hF is treated as ordinary data and fetching continues.

Decomposition:
- Shared package: state encoding (FETCH_IDLE, FETCH_WAIT, FETCH_DRAIN) and the HALT opcode constant, kept beside the existing CPU state constants.
- One sub-module: fetch_fifo (DEPTH x {16+AW}, push/pop/flush, count output).
- The PC and state machine live in inst_fetch.

Test Plan:
1. Reset release, zero-wait memory returning mem_rdata=16'h1000+addr, inst_ready=1 -> inst sequence 1000,1001,1002 with inst_pc 0,1,2; first inst_valid 3 cycles after reset.
2. inst_ready=0 held -> exactly DEPTH=2 requests issued, then mem_req stays 0; raising inst_ready for one cycle -> exactly one new request.
3. Memory with 4-cycle ack latency -> mem_addr and mem_req stable across all wait cycles; no duplicate pushes.
4. Redirect to 8'h40 while a request to 8'h05 is pending -> 8'h05 data discarded, next mem_addr=40, next valid inst_pc=40.
5. fetch_pc=8'hFF -> next request address 8'h00 (wrap).
6. IFU_HALT_EN defined, word F000 at addr 3 -> no request to addr 4 until redirect; with the macro undefined, addr 4 is fetched.
7. Reset asserted mid-WAIT -> mem_req=0 and inst_valid=0 immediately; a late mem_ack is ignored.

Source files
------------

// File: rtl/inst_fetch_pkg.sv
// Shared CPU/fetch constants: sequencer states, fetch FSM encoding, HALT opcode.
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    CPU_IF  = 2'd0,
    CPU_EX  = 2'd1,
    CPU_MEM = 2'd2,
    CPU_WB  = 2'd3
  } cpu_state_e;

  typedef enum logic [1:0] {
    FETCH_IDLE  = 2'd0,
    FETCH_WAIT  = 2'd1,
    FETCH_DRAIN = 2'd2
  } fetch_state_e;

  localparam logic [3:0] OP_HALT = 4'hF;

  function automatic logic is_halt(input logic [15:0] word);
    return word[15:12] == OP_HALT;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch FIFO with registered head outputs; head holds its last value when empty.
// Latency: a push into an empty FIFO is visible at the head one cycle later. Flush wins over push/pop.
module fetch_fifo #(
  parameter int W     = 24,
  parameter int DEPTH = 2,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          ck,
  input  logic          res,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  input  logic          flush,
  output logic [W-1:0]  head_dat,
  output logic          head_vld,
  output logic [CW-1:0] count
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [W-1:0]  head_q, head_d;
  logic          vld_q, vld_d;
  logic          do_pop;

  always_comb begin
    mem_d  = mem_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    cnt_d  = cnt_q;
    do_pop = pop && vld_q;
    if (flush) begin
      rd_d  = '0;
      wr_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) begin
        mem_d[wr_q] = push_dat;
        wr_d        = wr_q + PW'(1);
      end
      if (do_pop) begin
        rd_d = rd_q + PW'(1);
      end
      cnt_d = cnt_q + CW'(push) - CW'(do_pop);
    end
    // Head is precomputed from next-state so the outputs come straight from flops.
    vld_d  = (cnt_d != '0);
    head_d = vld_d ? mem_d[rd_d] : head_q;
  end

  always_ff @(posedge ck) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      rd_q   <= '0;
      wr_q   <= '0;
      cnt_q  <= '0;
      head_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      cnt_q  <= cnt_d;
      head_q <= head_d;
      vld_q  <= vld_d;
    end
  end

  assign head_dat = head_q;
  assign head_vld = vld_q;
  assign count    = cnt_q;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch: PC, single-outstanding memory requests, prefetch FIFO, redirect flush.
// Latency: first word valid 3 cycles after reset with zero-wait memory; stalls requesting when FIFO+outstanding is full.
// Optional IFU_HALT_EN: a fetched HALT opcode stops further requests until the next redirect.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter int              AW       = 8,
  parameter int              DEPTH    = 2,
  parameter logic [AW-1:0]   RESET_PC = '0
) (
  input  logic          ck,
  input  logic          res,
  output logic          mem_req,
  output logic [AW-1:0] mem_addr,
  input  logic          mem_ack,
  input  logic [15:0]   mem_rdata,
  output logic [15:0]   inst,
  output logic [AW-1:0] inst_pc,
  output logic          inst_valid,
  input  logic          inst_ready,
  input  logic          redirect,
  input  logic [AW-1:0] redirect_pc
);

  localparam int            CW      = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_e  state_q, state_d;
  logic          mem_req_q, mem_req_d;
  logic [AW-1:0] mem_addr_q, mem_addr_d;
  logic [AW-1:0] fetch_pc_q, fetch_pc_d;
  logic          halt_q, halt_d;

  logic          push, pop, halt_hit, can_issue, room_after;
  logic [CW-1:0] fifo_count, cnt_after;
  logic [15+AW:0] head_dat;

`ifdef IFU_HALT_EN
  assign halt_hit = is_halt(mem_rdata);
`else
  assign halt_hit = 1'b0;
`endif

  // A redirect kills the head in the same edge, so it must not also count as a pop.
  assign pop        = inst_valid && inst_ready && !redirect;
  assign cnt_after  = fifo_count + CW'(1) - CW'(pop);
  assign room_after = (cnt_after < DEPTH_C);
  assign can_issue  = (fifo_count < DEPTH_C) && !halt_q;

  always_comb begin
    state_d    = state_q;
    mem_req_d  = mem_req_q;
    mem_addr_d = mem_addr_q;
    fetch_pc_d = fetch_pc_q;
    halt_d     = halt_q;
    push       = 1'b0;
    if (redirect) begin
      fetch_pc_d = redirect_pc;
      halt_d     = 1'b0;
    end
    case (state_q)
      FETCH_IDLE: begin
        if (!redirect && can_issue) begin
          mem_req_d  = 1'b1;
          mem_addr_d = fetch_pc_q;
          state_d    = FETCH_WAIT;
        end
      end
      FETCH_WAIT: begin
        if (mem_ack && redirect) begin
          mem_addr_d = redirect_pc;
        end else if (mem_ack) begin
          push       = 1'b1;
          fetch_pc_d = fetch_pc_q + AW'(1);
          halt_d     = halt_q | halt_hit;
          if (room_after && !halt_hit) begin
            mem_addr_d = fetch_pc_q + AW'(1);
          end else begin
            mem_req_d = 1'b0;
            state_d   = FETCH_IDLE;
          end
        end else if (redirect) begin
          state_d = FETCH_DRAIN;
        end
      end
      FETCH_DRAIN: begin
        // The stale word is dropped; the newest redirect target is what gets requested.
        if (mem_ack) begin
          mem_addr_d = redirect ? redirect_pc : fetch_pc_q;
          state_d    = FETCH_WAIT;
        end
      end
      default: begin
        state_d   = FETCH_IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge ck or negedge res) begin
    if (!res) begin
      state_q    <= FETCH_IDLE;
      mem_req_q  <= 1'b0;
      mem_addr_q <= RESET_PC;
      fetch_pc_q <= RESET_PC;
      halt_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      mem_req_q  <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      fetch_pc_q <= fetch_pc_d;
      halt_q     <= halt_d;
    end
  end

  fetch_fifo #(
    .W     (16 + AW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .ck       (ck),
    .res      (res),
    .push     (push),
    .push_dat ({mem_rdata, mem_addr_q}),
    .pop      (pop),
    .flush    (redirect),
    .head_dat (head_dat),
    .head_vld (inst_valid),
    .count    (fifo_count)
  );

  assign mem_req  = mem_req_q;
  assign mem_addr = mem_addr_q;
  assign inst     = head_dat[15+AW:AW];
  assign inst_pc  = head_dat[AW-1:0];

endmodule

// File: tb/tb_inst_fetch.sv
// Bench for inst_fetch: behavioural memory with programmable ack latency and a popping scoreboard.
module tb_inst_fetch;

  typedef struct packed {
    logic [15:0] dat;
    logic [7:0]  pc;
  } exp_t;

  logic        ck = 1'b0;
  logic        res;
  logic        mem_req;
  logic [7:0]  mem_addr;
  logic        mem_ack = 1'b0;
  logic [15:0] mem_rdata = 16'h0;
  logic [15:0] inst;
  logic [7:0]  inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect;
  logic [7:0]  redirect_pc;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   lat = 1;
  logic halt_mode = 1'b0;
  logic force_ack = 1'b0;
  int   n_req = 0;
  int   wait_cnt = 0;
  logic prev_req = 1'b0;
  logic [7:0] prev_addr = 8'h0;
  int   last_pop = 0;
  int   last_gap = 0;
  exp_t exp_q[$];

  inst_fetch #(.AW(8), .DEPTH(2), .RESET_PC(8'h00)) dut (
    .ck(ck), .res(res),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  always #5 ck = ~ck;
  always @(posedge ck) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] rdata_fn(input logic [7:0] a);
    if (halt_mode && a == 8'h03) return 16'hF000;
    return 16'h1000 + {8'h00, a};
  endfunction

  task automatic expect_word(input logic [7:0] a);
    exp_q.push_back('{dat: rdata_fn(a), pc: a});
  endtask

  // Memory model: acks once a request has been seen for lat cycles; also checks request stability.
  always @(posedge ck) begin
    logic acked;
    #1;
    acked = mem_ack;
    if (mem_req && prev_req && !acked) chk("addr_stable", 32'(mem_addr), 32'(prev_addr));
    if (mem_req && (!prev_req || acked)) n_req++;
    prev_req  = mem_req;
    prev_addr = mem_addr;
    mem_ack   = 1'b0;
    if (force_ack) begin
      mem_ack   = 1'b1;
      mem_rdata = 16'hDEAD;
      wait_cnt  = 0;
    end else if (mem_req) begin
      if (wait_cnt >= lat) begin
        mem_ack   = 1'b1;
        mem_rdata = rdata_fn(mem_addr);
        wait_cnt  = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // Scoreboard monitor: every accepted word must match the oldest expectation.
  always @(negedge ck) begin
    exp_t e;
    if (res && inst_valid && inst_ready && !redirect) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_pop: got inst=%0h pc=%0h expected no word", inst, inst_pc);
      end else begin
        e = exp_q.pop_front();
        chk("pop_inst", 32'(inst), 32'(e.dat));
        chk("pop_pc", 32'(inst_pc), 32'(e.pc));
      end
      last_gap = cyc - last_pop;
      last_pop = cyc;
    end
  end

  task automatic do_reset();
    res = 1'b0;
    repeat (2) @(posedge ck);
    @(negedge ck);
    res = 1'b1;
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(posedge ck); #2;
      n++;
    end
    chk(name, 32'(exp_q.size()), 0);
    exp_q.delete();
    inst_ready = 1'b0;
  endtask

  task automatic pulse_redirect(input logic [7:0] pc);
    redirect    = 1'b1;
    redirect_pc = pc;
    @(posedge ck); #2;
    redirect = 1'b0;
  endtask

  initial begin
    int n;
    int base;
    res = 1'b0; inst_ready = 1'b1; redirect = 1'b0; redirect_pc = 8'h00;

    // Reset values, first-word latency, in-order stream and 1-per-2-cycle throughput.
    @(negedge ck);
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_mem_addr", 32'(mem_addr), 0);
    chk("rst_inst_valid", 32'(inst_valid), 0);
    chk("rst_inst", 32'(inst), 0);
    chk("rst_inst_pc", 32'(inst_pc), 0);
    repeat (2) @(posedge ck);
    for (int a = 0; a < 5; a++) expect_word(8'(a));
    @(negedge ck);
    res = 1'b1;
    n = 0;
    while (!inst_valid && n < 20) begin
      @(posedge ck); @(negedge ck);
      n++;
    end
    chk("t1_first_valid_lat", 32'(n), 3);
    drain("t1_drain", 100);
    chk("t1_gap", 32'(last_gap), 2);

    // Backpressure: exactly DEPTH requests, then one more per pop.
    lat = 1; inst_ready = 1'b0;
    do_reset();
    base = n_req;
    repeat (20) @(posedge ck); #2;
    chk("t2_req_cnt_full", 32'(n_req - base), 2);
    chk("t2_req_low", 32'(mem_req), 0);
    chk("t2_valid", 32'(inst_valid), 1);
    expect_word(8'h00);
    inst_ready = 1'b1;
    @(posedge ck); #2;
    inst_ready = 1'b0;
    repeat (20) @(posedge ck); #2;
    chk("t2_req_cnt_one_more", 32'(n_req - base), 3);
    chk("t2_req_low2", 32'(mem_req), 0);
    for (int a = 1; a < 4; a++) expect_word(8'(a));
    inst_ready = 1'b1;
    drain("t2_drain", 100);

    // Slow memory: request held stable, no duplicate words.
    lat = 4; inst_ready = 1'b1;
    do_reset();
    for (int a = 0; a < 4; a++) expect_word(8'(a));
    drain("t3_drain", 200);

    // Redirect to 40 while the request to 05 is pending.
    lat = 4; inst_ready = 1'b1;
    do_reset();
    for (int a = 0; a < 4; a++) expect_word(8'(a));
    n = 0;
    while (!(mem_req && mem_addr == 8'h05) && n < 100) begin
      @(posedge ck); #2;
      n++;
    end
    chk("t4_req05_seen", 32'(mem_req && mem_addr == 8'h05), 1);
    chk("t4_pre_empty", 32'(exp_q.size()), 0);
    exp_q.delete();
    expect_word(8'h40);
    expect_word(8'h41);
    pulse_redirect(8'h40);
    @(negedge ck);
    chk("t4_flush_valid", 32'(inst_valid), 0);
    n = 0;
    while (!mem_ack && n < 20) begin
      @(negedge ck);
      n++;
    end
    chk("t4_drain_ack_seen", 32'(mem_ack), 1);
    chk("t4_drain_ack_addr", 32'(mem_addr), 32'h05);
    @(negedge ck);
    chk("t4_new_req", 32'(mem_req), 1);
    chk("t4_new_addr", 32'(mem_addr), 32'h40);
    drain("t4_drain", 200);

    // Address wrap from FF to 00.
    lat = 1; inst_ready = 1'b1;
    res = 1'b0;
    repeat (2) @(posedge ck);
    expect_word(8'hFF);
    expect_word(8'h00);
    expect_word(8'h01);
    @(negedge ck);
    res = 1'b1;
    pulse_redirect(8'hFF);
    n = 0;
    while (!mem_ack && n < 20) begin
      @(negedge ck);
      n++;
    end
    chk("t5_ack_addr", 32'(mem_addr), 32'hFF);
    @(negedge ck);
    chk("t5_wrap_req", 32'(mem_req), 1);
    chk("t5_wrap_addr", 32'(mem_addr), 0);
    drain("t5_drain", 100);

    // HALT opcode at address 3.
    lat = 1; halt_mode = 1'b1; inst_ready = 1'b1;
    do_reset();
    base = n_req;
    for (int a = 0; a < 4; a++) expect_word(8'(a));
`ifdef IFU_HALT_EN
    drain("t6_drain_pre_halt", 100);
    repeat (20) @(posedge ck); #2;
    chk("t6_halt_req_cnt", 32'(n_req - base), 4);
    chk("t6_halt_req_low", 32'(mem_req), 0);
    inst_ready = 1'b1;
    expect_word(8'h10);
    pulse_redirect(8'h10);
    drain("t6_drain_after_redirect", 100);
`else
    expect_word(8'h04);
    expect_word(8'h05);
    drain("t6_drain_no_halt", 100);
    chk("t6_fetched_past_f000", 32'(n_req - base >= 6), 1);
`endif
    halt_mode = 1'b0;

    // Reset in the middle of a wait, then a stray ack while no request is out.
    lat = 4; inst_ready = 1'b0;
    do_reset();
    n = 0;
    while (!(inst_valid && mem_req) && n < 100) begin
      @(posedge ck); #2;
      n++;
    end
    chk("t7_busy_before_reset", 32'(inst_valid && mem_req), 1);
    res = 1'b0;
    #1;
    chk("t7_rst_mem_req", 32'(mem_req), 0);
    chk("t7_rst_valid", 32'(inst_valid), 0);
    @(posedge ck); #2;
    force_ack = 1'b1;
    @(posedge ck); #2;
    force_ack = 1'b0;
    expect_word(8'h00);
    expect_word(8'h01);
    inst_ready = 1'b1;
    @(negedge ck);
    res = 1'b1;
    @(negedge ck);
    chk("t7_late_ack_ignored", 32'(inst_valid), 0);
    chk("t7_req_after_reset", 32'(mem_req), 1);
    chk("t7_addr_after_reset", 32'(mem_addr), 0);
    drain("t7_drain", 200);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
